// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART-driven bus master: command opcodes,
// response bytes and the command FSM encoding.
package uart_bus_master_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] OP_RESET = 8'h58;  // 'X'

    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN,
        ST_WAIT_DATA,
        ST_WAIT_GNT,
        ST_ACCESS,
        ST_GAP,
        ST_SEND,
        ST_RST,
        ST_ACKBYTE
    } state_t;

    // A length byte of zero encodes a 256-byte transfer.
    function automatic logic [8:0] decode_len(input logic [7:0] n);
        return (n == 8'h00) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/uart_bus_master_timer.sv
// Bus access timer: counts cycles spent waiting for a slave acknowledge and
// flags the terminal count once ACK_TIMEOUT cycles of the access have elapsed.
module uart_bus_master_timer #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_run,
    output logic o_tc
);

    localparam logic [7:0] TC_LAST = 8'(ACK_TIMEOUT - 1);

    logic [7:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_start) begin
            count_q <= '0;
        end else if (i_run && !o_tc) begin
            count_q <= count_q + 8'd1;
        end
    end

    // Terminal count is reached in the ACK_TIMEOUT-th cycle of the access.
    assign o_tc = i_run && (count_q == TC_LAST);

endmodule

// File: rtl/uart_bus_master.sv
// Second bus initiator on the 8-bit system bus, driven by a UART byte command
// stream: bulk write, bulk read with streamed replies, and a CPU reset pulse.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned RESET_PULSE = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_dat,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busreq,
    input  logic        i_busgnt,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dat,
    input  logic [7:0]  i_dat,
    output logic        o_cs,
    output logic        o_we,
    input  logic        i_ack,
    output logic        o_sys_reset,
    output logic        o_error
);

    localparam int unsigned RST_W = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_PULSE - 1);

    state_t            state_q,    state_d;
    logic [15:0]       addr_q,     addr_d;
    logic [7:0]        dat_q,      dat_d;
    logic [8:0]        len_q,      len_d;
    logic [7:0]        rd_q,       rd_d;
    logic              is_write_q, is_write_d;
    logic              err_q,      err_d;
    logic [RST_W-1:0]  rst_cnt_q,  rst_cnt_d;

    logic timer_start;
    logic timer_tc;

    uart_bus_master_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (timer_start),
        .i_run   (state_q == ST_ACCESS),
        .o_tc    (timer_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            dat_q      <= '0;
            len_q      <= '0;
            rd_q       <= '0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            rst_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            len_q      <= len_d;
            rd_q       <= rd_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            rst_cnt_q  <= rst_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        dat_d       = dat_q;
        len_d       = len_q;
        rd_d        = rd_q;
        is_write_d  = is_write_q;
        err_d       = err_q;
        rst_cnt_d   = rst_cnt_q;
        timer_start = 1'b0;
        o_busreq    = 1'b0;
        o_cs        = 1'b0;
        o_we        = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_dat    = 8'h00;
        o_sys_reset = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    unique case (i_rx_dat)
                        OP_WRITE: begin
                            is_write_d = 1'b1;
                            err_d      = 1'b0;
                            state_d    = ST_ADDR_H;
                        end
                        OP_READ: begin
                            is_write_d = 1'b0;
                            err_d      = 1'b0;
                            state_d    = ST_ADDR_H;
                        end
                        OP_RESET: begin
                            err_d     = 1'b0;
                            rst_cnt_d = '0;
                            state_d   = ST_RST;
                        end
                        default: ;
                    endcase
                end
            end

            ST_ADDR_H: begin
                if (i_rx_valid) begin
                    addr_d[15:8] = i_rx_dat;
                    state_d      = ST_ADDR_L;
                end
            end

            ST_ADDR_L: begin
                o_busreq = 1'b1;
                if (i_rx_valid) begin
                    addr_d[7:0] = i_rx_dat;
                    state_d     = ST_LEN;
                end
            end

            ST_LEN: begin
                o_busreq = 1'b1;
                if (i_rx_valid) begin
                    len_d   = decode_len(i_rx_dat);
                    state_d = is_write_q ? ST_WAIT_DATA : ST_WAIT_GNT;
                end
            end

            ST_WAIT_DATA: begin
                o_busreq = 1'b1;
                if (i_rx_valid) begin
                    dat_d   = i_rx_dat;
                    state_d = ST_WAIT_GNT;
                end
            end

            ST_WAIT_GNT: begin
                o_busreq = 1'b1;
                if (i_busgnt) begin
                    timer_start = 1'b1;
                    state_d     = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                o_busreq = 1'b1;
                o_cs     = 1'b1;
                o_we     = is_write_q;
                // Acknowledge takes priority over a coincident timeout.
                if (i_ack) begin
                    if (!is_write_q) begin
                        rd_d = i_dat;
                    end
                    addr_d  = addr_q + 16'd1;
                    len_d   = len_q - 9'd1;
                    state_d = ST_GAP;
                end else if (timer_tc) begin
                    err_d   = 1'b1;
                    state_d = ST_ACKBYTE;
                end
            end

            ST_GAP: begin
                o_busreq = 1'b1;
                if (is_write_q) begin
                    state_d = (len_q == 9'd0) ? ST_ACKBYTE : ST_WAIT_DATA;
                end else begin
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                o_busreq   = 1'b1;
                o_tx_valid = 1'b1;
                o_tx_dat   = rd_q;
                if (i_tx_ready) begin
                    state_d = (len_q == 9'd0) ? ST_ACKBYTE : ST_WAIT_GNT;
                end
            end

            ST_RST: begin
                o_sys_reset = 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_ACKBYTE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            ST_ACKBYTE: begin
                o_tx_valid = 1'b1;
                o_tx_dat   = err_q ? RSP_NAK : RSP_ACK;
                if (i_tx_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign o_addr  = addr_q;
    assign o_dat   = dat_q;
    assign o_error = err_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed self-checking bench for uart_bus_master with a behavioural memory
// slave, a grant-on-request arbiter and a logging UART transmit sink.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  rx_dat;
    logic        rx_valid;
    logic [7:0]  o_tx_dat;
    logic        o_tx_valid;
    logic        tx_rdy;
    logic        o_busreq;
    logic        gnt_en;
    logic        busgnt;
    logic [15:0] o_addr;
    logic [7:0]  o_dat;
    logic [7:0]  rdat;
    logic        o_cs;
    logic        o_we;
    logic        ack;
    logic        o_sys_reset;
    logic        o_error;

    int n_checks = 0;
    int n_errors = 0;

    // Slave and monitor state
    logic [7:0]  mem [0:65535];
    logic        ack_en;
    int          ack_delay;
    int          cs_age      = 0;
    int          low_run     = 0;
    int          last_cs_len = 0;
    int          cs_rises    = 0;
    int          rst_hi      = 0;
    logic [15:0] wr_addr_q [$];
    logic [7:0]  wr_dat_q  [$];
    logic [15:0] rd_addr_q [$];
    logic [7:0]  tx_q      [$];

    always #5 clk = ~clk;

    assign busgnt = gnt_en && o_busreq;

    uart_bus_master #(
        .ACK_TIMEOUT (255),
        .RESET_PULSE (16)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_rx_dat    (rx_dat),
        .i_rx_valid  (rx_valid),
        .o_tx_dat    (o_tx_dat),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (tx_rdy),
        .o_busreq    (o_busreq),
        .i_busgnt    (busgnt),
        .o_addr      (o_addr),
        .o_dat       (o_dat),
        .i_dat       (rdat),
        .o_cs        (o_cs),
        .o_we        (o_we),
        .i_ack       (ack),
        .o_sys_reset (o_sys_reset),
        .o_error     (o_error)
    );

    // Mid-cycle slave/monitor: ack rises ack_delay cycles after cs, and is
    // sampled by the DUT on the following rising edge.
    always @(negedge clk) begin
        if (o_cs) begin
            if (cs_age == 0) begin
                cs_rises++;
                low_run = 0;
            end
            cs_age++;
        end else begin
            if (cs_age != 0) last_cs_len = cs_age;
            cs_age = 0;
            low_run++;
        end
        ack  = ack_en && o_cs && (cs_age == ack_delay + 1);
        rdat = mem[o_addr];
        if (o_cs && ack) begin
            if (o_we) begin
                mem[o_addr] = o_dat;
                wr_addr_q.push_back(o_addr);
                wr_dat_q.push_back(o_dat);
            end else begin
                rd_addr_q.push_back(o_addr);
            end
        end
        if (o_tx_valid && tx_rdy) tx_q.push_back(o_tx_dat);
        if (o_sys_reset) rst_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_dat   = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_dat_q.delete();
        rd_addr_q.delete();
        tx_q.delete();
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && tx_q.size() < n; i++) step();
        if (tx_q.size() < n) check("tx_wait_expired", tx_q.size(), n);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wr_addr_q.size() < n; i++) step();
        if (wr_addr_q.size() < n) check("write_wait_expired", wr_addr_q.size(), n);
    endtask

    task automatic wait_cs_or_txv(input bit want_tx, input int budget);
        for (int i = 0; i < budget && !(want_tx ? o_tx_valid : o_cs); i++) step();
        check(want_tx ? "tx_valid_seen" : "cs_seen", want_tx ? o_tx_valid : o_cs, 1);
    endtask

    initial begin
        int held;
        int cs_hi;
        int rises0;

        i_reset   = 1'b1;
        rx_dat    = 8'h00;
        rx_valid  = 1'b0;
        tx_rdy    = 1'b1;
        gnt_en    = 1'b1;
        ack_en    = 1'b1;
        ack_delay = 2;
        repeat (3) step();
        @(negedge clk);
        check("reset_ctrl", {o_cs, o_we, o_busreq, o_tx_valid, o_sys_reset, o_error}, 0);
        check("reset_addr", o_addr, 16'h0000);
        check("reset_dat",  o_dat, 8'h00);
        step();
        i_reset = 1'b0;
        step();

        // Two-byte write, ack two cycles after cs
        rx(8'h57); rx(8'h12); rx(8'h34); rx(8'h02); rx(8'hAA);
        wait_writes(1, 50);
        @(negedge clk);
        check("gap_cs_low",    o_cs, 0);
        check("gap_busreq",    o_busreq, 1);
        step();
        rx(8'hBB);
        wait_tx(1, 50);
        check("wr0_addr", wr_addr_q[0], 16'h1234);
        check("wr0_dat",  wr_dat_q[0],  8'hAA);
        check("wr1_addr", wr_addr_q[1], 16'h1235);
        check("wr1_dat",  wr_dat_q[1],  8'hBB);
        check("wr_cs_len", last_cs_len, 3);
        check("wr_resp",  tx_q[0], 8'h06);
        step();
        check("wr_busreq_released", o_busreq, 0);

        // Two-byte read with transmitter back-pressure
        clear_logs();
        mem[16'hF000] = 8'h5A;
        mem[16'hF001] = 8'hC3;
        ack_delay = 1;
        tx_rdy    = 1'b0;
        rx(8'h52); rx(8'hF0); rx(8'h00); rx(8'h02);
        wait_cs_or_txv(1'b1, 50);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_tx_valid && o_tx_dat == 8'h5A && o_busreq) held++;
        end
        check("tx_held", held, 10);
        step();
        tx_rdy = 1'b1;
        wait_tx(3, 50);
        check("rd0_addr", rd_addr_q[0], 16'hF000);
        check("rd1_addr", rd_addr_q[1], 16'hF001);
        check("rd_tx0", tx_q[0], 8'h5A);
        check("rd_tx1", tx_q[1], 8'hC3);
        check("rd_resp", tx_q[2], 8'h06);

        // Address wrap
        step();
        clear_logs();
        mem[16'hFFFF] = 8'h77;
        mem[16'h0000] = 8'h88;
        rx(8'h52); rx(8'hFF); rx(8'hFF); rx(8'h02);
        wait_tx(3, 50);
        check("wrap_addr0", rd_addr_q[0], 16'hFFFF);
        check("wrap_addr1", rd_addr_q[1], 16'h0000);
        check("wrap_tx0", tx_q[0], 8'h77);
        check("wrap_tx1", tx_q[1], 8'h88);
        check("wrap_resp", tx_q[2], 8'h06);

        // Timeout on a write that is never acknowledged
        step();
        clear_logs();
        ack_en = 1'b0;
        rx(8'h57); rx(8'hFA); rx(8'h30); rx(8'h01); rx(8'h11);
        wait_tx(1, 600);
        check("to_cs_len", last_cs_len, 255);
        check("to_resp", tx_q[0], 8'h15);
        check("to_no_write", wr_addr_q.size(), 0);
        step();
        check("to_error_set", o_error, 1);
        ack_en = 1'b1;

        // Next valid opcode clears the sticky error
        clear_logs();
        mem[16'h0010] = 8'h3C;
        rx(8'h52);
        check("error_cleared", o_error, 0);
        rx(8'h00); rx(8'h10); rx(8'h01);
        wait_tx(2, 50);
        check("clr_tx0", tx_q[0], 8'h3C);
        check("clr_resp", tx_q[1], 8'h06);

        // Reset pulse command
        step();
        clear_logs();
        rst_hi = 0;
        rx(8'h58);
        wait_tx(1, 100);
        check("rst_pulse_len", rst_hi, 16);
        check("rst_resp", tx_q[0], 8'h06);

        // Reset in the middle of a multi-byte write
        step();
        ack_en = 1'b0;
        rx(8'h57); rx(8'h20); rx(8'h00); rx(8'h04); rx(8'h01);
        wait_cs_or_txv(1'b0, 20);
        i_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_drop", {o_cs, o_busreq, o_tx_valid}, 0);
        step();
        i_reset = 1'b0;
        ack_en  = 1'b1;
        step();

        // Reset while a read byte is pending on tx
        tx_rdy = 1'b0;
        rx(8'h52); rx(8'h00); rx(8'h10); rx(8'h01);
        wait_cs_or_txv(1'b1, 50);
        i_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("txreset_drop", {o_tx_valid, o_busreq}, 0);
        step();
        i_reset = 1'b0;
        tx_rdy  = 1'b1;
        step();

        // Unknown opcode is ignored
        clear_logs();
        rises0 = cs_rises;
        rx(8'h41);
        repeat (20) step();
        check("unk_no_cs", cs_rises - rises0, 0);
        check("unk_no_tx", tx_q.size(), 0);
        check("unk_no_busreq", o_busreq, 0);

        // Grant withheld for 20 cycles after LEN
        mem[16'h0100] = 8'hA5;
        gnt_en = 1'b0;
        rx(8'h52); rx(8'h01); rx(8'h00); rx(8'h01);
        cs_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_cs) cs_hi++;
        end
        check("nognt_cs_low", cs_hi, 0);
        check("nognt_busreq", o_busreq, 1);
        step();
        gnt_en = 1'b1;
        wait_tx(2, 50);
        check("gnt_tx0", tx_q[0], 8'hA5);
        check("gnt_resp", tx_q[1], 8'h06);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
Second bus initiator for the 8-bit system bus, driven by a byte-level command stream from the UART receiver. It lets a host load program memory, peek and poke memory-mapped registers, and pulse a CPU reset over serial. It sits beside the CPU master. An external arbiter grants the bus when o_busreq is high, so this block issues cs/we/addr cycles and waits for ack exactly as the CPU does. Read data and status bytes go back out on the UART transmit byte stream.

Parameters:
ACK_TIMEOUT, 255, cycles to wait for i_ack after o_cs asserts before the access is aborted (8-bit counter, value 1..255)
RESET_PULSE, 16, width in cycles of the o_sys_reset pulse

Ports:
i_clk  in  1  system clock; the single clock domain
i_reset  in  1  synchronous, active-high reset
i_rx_dat  in  8  received byte from UART receiver
i_rx_valid  in  1  one-cycle strobe: i_rx_dat is valid
o_tx_dat  out  8  byte to transmit
o_tx_valid  out  1  o_tx_dat valid; held until accepted
i_tx_ready  in  1  transmitter accepts byte when o_tx_valid && i_tx_ready
o_busreq  out  1  bus requested; high from first address byte until the end of the command
i_busgnt  in  1  bus granted
o_addr  out  16  bus address
o_dat  out  8  write data
i_dat  in  8  read data, valid in the cycle i_ack is high
o_cs  out  1  bus cycle active
o_we  out  1  write enable, qualified by o_cs
i_ack  in  1  slave acknowledge
o_sys_reset  out  1  reset pulse to the CPU and peripherals
o_error  out  1  sticky: last command aborted on timeout; cleared by the next valid opcode

Behaviour:
- Reset values:
  - all outputs 0; o_addr=0x0000.
  - FSM in IDLE; counters cleared.
  - A reset mid-command abandons it: o_cs drops at once and no tx byte is pending.
- Command protocol:
  - 0x57 'W' AH AL N D0..D(N-1): write N bytes starting at address AH:AL.
  - 0x52 'R' AH AL N: read N bytes; each byte is transmitted as it is read.
  - 0x58 'X': reset pulse.
  - N=0 means 256.
  - Any other opcode in IDLE is ignored; no response is sent.
- Addressing: address increments by 1 after each access and wraps from 0xFFFF to 0x0000. The length counter is 9 bits.
- FSM states: IDLE, ADDR_H, ADDR_L, LEN, WAIT_DATA, WAIT_GNT, ACCESS, GAP, SEND, RST, ACKBYTE.
- Transitions:
  - IDLE → ADDR_H on 'W' or 'R'; IDLE → RST on 'X'.
  - ADDR_H → ADDR_L → LEN, each on a valid rx byte.
  - LEN → WAIT_DATA for a write, or WAIT_GNT for a read.
  - WAIT_DATA latches the data byte into o_dat, then → WAIT_GNT.
  - WAIT_GNT → ACCESS when i_busgnt.
  - ACCESS drives o_cs=1 (and o_we=1 for a write).
  - ACCESS exits when i_ack is sampled high. For a read, i_dat is captured in that same cycle.
  - ACCESS → GAP for a single cycle with o_cs=0, so consecutive accesses are never back-to-back.
  - After GAP: write → WAIT_DATA (or ACKBYTE if this was the last byte); read → SEND.
  - SEND holds o_tx_valid until i_tx_ready, then → WAIT_GNT, or ACKBYTE if this was the last byte.
  - ACKBYTE sends 0x06 on success or 0x15 on timeout, then → IDLE.
  - RST drives o_sys_reset for RESET_PULSE cycles, then → ACKBYTE.
- Bus request: o_busreq stays asserted across WAIT_DATA/SEND gaps. It deasserts in ACKBYTE.
- o_addr and o_dat stay stable while o_cs=1. The slave-select decoder is registered, so i_ack may arrive 1 or more cycles after o_cs.
- Timeout:
  - The counter starts on entry to ACCESS.
  - On reaching ACK_TIMEOUT with no ack: drop o_cs, set o_error, skip the remaining bytes, → ACKBYTE (0x15).
  - For a write, remaining data bytes still arriving on rx are discarded as opcodes in IDLE; the host must resync.
- Edge cases:
  - If i_ack and the timeout terminal count happen in the same cycle, ack wins.
  - rx bytes arriving in ACCESS/SEND/GAP/RST/ACKBYTE are dropped; the host must pace writes to at most one byte per bus access.
  - i_busgnt deasserting mid-ACCESS is illegal (the arbiter must not revoke the grant); behaviour is unspecified.

Decomposition:
- Shared package: opcode constants (0x57, 0x52, 0x58), response bytes (0x06, 0x15), FSM state encoding.
- One sub-module is natural: bus_access_timer, the 8-bit timeout counter with start/clear/terminal-count outputs.

Test Plan:
- rx 57 12 34 02 AA BB, ack 2 cycles after cs → two writes: 0x1234=AA, then 0x1235=BB; one-cycle cs gap between them; tx 06.
- Preload mem 0xF000=5A, 0xF001=C3; rx 52 F0 00 02 → tx 5A, C3, 06. Hold i_tx_ready low for 10 cycles and confirm o_tx_valid and the data stay held.
- rx 52 FF FF 02 → accesses at 0xFFFF then 0x0000 (wrap).
- rx 57 FA 30 01 11, never ack → o_cs high for exactly 255 cycles, tx 15, o_error=1. The next rx 52 … clears o_error.
- rx 58 → o_sys_reset high for 16 cycles, then tx 06. Assert i_reset during a multi-byte write → o_cs, o_busreq, o_tx_valid drop next cycle and FSM returns to IDLE.
- rx 41 (unknown opcode) → no bus activity, no tx. Keep i_busgnt=0 for 20 cycles after LEN → o_cs stays 0 until the grant arrives.
